// File: rtl/bp_debug_unit.sv
// Memory-mapped hardware breakpoint unit: NUM_BP exec/read/write channels with hit
// counters, sticky status, captured hit address and a halt/ack/resume handshake.
module bp_debug_unit #(
    parameter int unsigned       NUM_BP = 4,
    parameter int unsigned       ADDR_W = 32,
    parameter int unsigned       DATA_W = 16,
    parameter logic [ADDR_W-1:0] BASE   = ADDR_W'(32'hFFFFF000),
    parameter int unsigned       CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              we,
    input  logic              re,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              sel,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pcValid,
    input  logic [ADDR_W-1:0] memAddr,
    input  logic              memRe,
    input  logic              memWe,
    output logic              haltReq,
    input  logic              haltAck,
    output logic              halted
);
    localparam int unsigned NREG   = 4 * NUM_BP + 4;
    localparam int unsigned OFF_W  = $clog2(NREG);
    localparam int unsigned WIN    = 1 << OFF_W;
    localparam int unsigned CIDX_W = OFF_W - 2;
    localparam int unsigned AHI_W  = ADDR_W - 16;

    typedef enum logic [1:0] {RUN, HALT_REQ, HALTED} stateT;

    stateT              state;
    logic [NUM_BP-1:0]  enR, execR, readR, writeR, status;
    logic [NUM_BP-1:0]  execM, dataM, match, trig, chWr, statusClr;
    logic [CNT_W-1:0]   thr    [NUM_BP];
    logic [CNT_W-1:0]   cnt    [NUM_BP];
    logic [CNT_W-1:0]   cntInc [NUM_BP];
    logic [ADDR_W-1:0]  bpAddr [NUM_BP];
    logic [ADDR_W-1:0]  hitAddr, hitNext, offFull;
    logic [OFF_W-1:0]   off;
    logic [CIDX_W-1:0]  chIdx;
    logic [1:0]         regIdx;
    logic               isChan, isGlobal, busWr, resume;
    logic [DATA_W-1:0]  rdMux;

    // Window is the register file rounded up to a power of two; the tail reads as 0.
    assign offFull   = addr - BASE;
    assign sel       = (addr >= BASE) && (offFull < ADDR_W'(WIN));
    assign off       = offFull[OFF_W-1:0];
    assign chIdx     = off[OFF_W-1:2];
    assign regIdx    = off[1:0];
    assign isChan    = chIdx < CIDX_W'(NUM_BP);
    assign isGlobal  = chIdx == CIDX_W'(NUM_BP);
    assign busWr     = we && sel;
    assign resume    = busWr && isGlobal && (regIdx == 2'd3) && (state == HALTED);
    assign statusClr = (busWr && isGlobal && regIdx == 2'd0) ? wdata[NUM_BP-1:0] : '0;

    // Descending scan so the lowest triggering channel supplies the hit address.
    always_comb begin
        execM   = '0;
        dataM   = '0;
        match   = '0;
        trig    = '0;
        chWr    = '0;
        hitNext = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            cntInc[i] = (&cnt[i]) ? cnt[i] : cnt[i] + 1'b1;
            chWr[i]   = busWr && isChan && (chIdx == CIDX_W'(i));
            execM[i]  = enR[i] && execR[i] && pcValid && (pc == bpAddr[i]);
            dataM[i]  = enR[i] && ((readR[i] && memRe) || (writeR[i] && memWe))
                        && (memAddr == bpAddr[i]);
            match[i]  = (state == RUN) && (execM[i] || dataM[i]) && !chWr[i];
            trig[i]   = match[i] && (cntInc[i] >= ((thr[i] == '0) ? CNT_W'(1) : thr[i]));
            if (trig[i]) hitNext = execM[i] ? pc : memAddr;
        end
    end

    always_comb begin
        rdMux = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (isChan && chIdx == CIDX_W'(i)) begin
                case (regIdx)
                    2'd0: begin
                        rdMux[3:0]       = {writeR[i], readR[i], execR[i], enR[i]};
                        rdMux[8 +: CNT_W] = thr[i];
                    end
                    2'd1:    rdMux = DATA_W'(bpAddr[i][15:0]);
                    2'd2:    rdMux = DATA_W'(bpAddr[i][ADDR_W-1:16]);
                    default: rdMux = DATA_W'(cnt[i]);
                endcase
            end
        end
        if (isGlobal) begin
            case (regIdx)
                2'd0:    rdMux = DATA_W'(status);
                2'd1:    rdMux = DATA_W'(hitAddr[15:0]);
                2'd2:    rdMux = DATA_W'(hitAddr[ADDR_W-1:16]);
                default: rdMux = DATA_W'(halted);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            haltReq <= 1'b0;
            halted  <= 1'b0;
            ready   <= 1'b0;
            rdata   <= '0;
            status  <= '0;
            hitAddr <= '0;
            enR     <= '0;
            execR   <= '0;
            readR   <= '0;
            writeR  <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                thr[i]    <= '0;
                cnt[i]    <= '0;
                bpAddr[i] <= '0;
            end
        end else begin
            ready <= re && sel;
            rdata <= (re && sel) ? rdMux : '0;
            for (int i = 0; i < NUM_BP; i++) begin
                if (chWr[i] && regIdx == 2'd0) begin
                    enR[i]    <= wdata[0];
                    execR[i]  <= wdata[1];
                    readR[i]  <= wdata[2];
                    writeR[i] <= wdata[3];
                    thr[i]    <= wdata[8 +: CNT_W];
                end
                if (chWr[i] && regIdx == 2'd1) bpAddr[i][15:0] <= wdata[15:0];
                if (chWr[i] && regIdx == 2'd2) bpAddr[i][ADDR_W-1:16] <= wdata[AHI_W-1:0];
                // Resume restarts counting only on channels that actually fired.
                if ((chWr[i] && regIdx == 2'd3) || (resume && status[i])) cnt[i] <= '0;
                else if (match[i]) cnt[i] <= cntInc[i];
            end
            status <= (status & ~statusClr) | trig;
            if (|trig) hitAddr <= hitNext;
            case (state)
                RUN: if (|trig) begin
                    state   <= HALT_REQ;
                    haltReq <= 1'b1;
                end
                HALT_REQ: if (haltAck) begin
                    state   <= HALTED;
                    haltReq <= 1'b0;
                    halted  <= 1'b1;
                end
                HALTED: if (resume) begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
                default: begin
                    state   <= RUN;
                    haltReq <= 1'b0;
                    halted  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/bp_debug_unit.md
Name: bp_debug_unit

Overview:
- Parametrised successor to the fixed four-entry memory-mapped breakpoint registers.
- Provides NUM_BP breakpoint channels with exec/read/write match modes, per-channel hit counters and thresholds, sticky status, and captured hit address.
- Runs a halt-request/acknowledge/resume handshake with the CPU core.
- Sits beside the RAM/MMIO decoder on the CPU data bus and snoops the instruction-fetch and data-access streams.

Parameters:
- NUM_BP, 4, number of breakpoint channels (1..16).
- ADDR_W, 32, bus/PC address width.
- DATA_W, 16, bus data width; must be at least 16.
- BASE, 32'hFFFFF000, first register address of the block.
- CNT_W, 8, hit counter and threshold width; must be at most DATA_W-8.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- addr  in  ADDR_W  bus address
- wdata  in  DATA_W  bus write data
- we  in  1  bus write strobe
- re  in  1  bus read strobe
- rdata  out  DATA_W  read data; valid only while ready=1
- ready  out  1  read-data-valid pulse
- sel  out  1  combinational: addr lies in this block's register window
- pc  in  ADDR_W  fetch address
- pcValid  in  1  fetch occurs this cycle
- memAddr  in  ADDR_W  data access address
- memRe  in  1  data read this cycle
- memWe  in  1  data write this cycle
- haltReq  out  1  request core to halt
- haltAck  in  1  core reports it has halted
- halted  out  1  unit is in the HALTED state

Behaviour:
Clock and reset:
- One clock: clk.
- Reset is synchronous, active-high, on rst.
- Reset values: all registers 0, haltReq=0, halted=0, ready=0, rdata=0, state=RUN.
- rst asserted in any state returns to RUN on the next edge, even mid-halt.

Register map (word offsets from BASE, per channel i at 4*i):
- +0 ctrl: bit0 en, bit1 exec, bit2 read, bit3 write, bits[8+CNT_W-1:8] threshold.
- +1 address low 16 bits.
- +2 address high bits.
- +3 hit count: read-only value; any write clears it.

Global registers at G=BASE+4*NUM_BP:
- G+0 status: NUM_BP sticky hit bits, write-1-to-clear.
- G+1 hit address low.
- G+2 hit address high.
- G+3 control: bit0 state-machine halted (read); any write issues resume.

Register access:
- Unmapped offsets inside the window read 0; writes to them are ignored.
- Writes take effect at the edge where we=1.
- Reads are registered: re at cycle N gives rdata and ready=1 at cycle N+1, for one cycle.
- Back-to-back reads are supported.
- ready=0 whenever re was low or addr was outside the window on the previous cycle.

Matching (combinational compare, registered effect):
- A channel matches when en=1 and either:
  - exec=1, pcValid=1, pc==address; or
  - (read=1 and memRe=1) or (write=1 and memWe=1), and memAddr==address.
- Matches are evaluated only in state RUN.
- A matching channel's count increments, saturating at all-ones.
- If a bus write targets a channel's registers in the same cycle as its match, the write wins and the match is discarded for that channel.

Trigger:
- A channel triggers when its incremented count is at least the effective threshold. A threshold of 0 is treated as 1.
- On any trigger:
  - status bits are set for all triggering channels;
  - hit address captures the match address of the lowest-index triggering channel (pc for an exec match, else memAddr; exec takes precedence within a channel);
  - next state is HALT_REQ.

State machine:
- RUN -> HALT_REQ on trigger.
- HALT_REQ: haltReq=1 (registered, asserted the cycle after the trigger edge); goes to HALTED when haltAck=1.
- HALTED: haltReq=0, halted=1.
- Resume write in HALTED: go to RUN and clear the count of every channel whose status bit is set. Status bits themselves are kept.
- Resume write in RUN or HALT_REQ is ignored.
- haltAck outside HALT_REQ is ignored.

Test Plan:
1. Reset, then write ch0 ctrl=16'h0103 and addr=32'h00000040; drive pc=0x40 with pcValid=1 -> status=1, hit addr=0x40, haltReq=1 on the next cycle; haltAck -> halted=1, haltReq=0.
2. Set ch1 ctrl threshold=3 with write mode at 0xD0000010; perform three memWe accesses to that address -> count reads 1, 2, then halt on the third; a read reaches no trigger.
3. Trigger ch0 and ch2 in the same cycle with different addresses -> status=4'b0101, hit addr taken from ch0.
4. While HALTED, assert pcValid on a matching pc -> count unchanged; write G+3 -> state RUN, triggered counts=0; W1C write of 1 to status bit0 -> bit clears.
5. Read ch0 addr low with re at cycle N -> ready=1 and correct rdata at N+1 only; read an unmapped offset -> 0.
6. Assert rst during HALT_REQ -> next cycle haltReq=0, halted=0, all registers 0.
